// File: rtl/dir_sweep_sched.sv
// Sweep sequencer for the RTC register address path: grants write/read sweeps
// (write first), issues one bus transaction per address and aborts a stalled bus.
`timescale 1ns/1ps
module dir_sweep_sched #(
  parameter int ADDR_W  = 4,
  parameter int N_REGS  = 9,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_req,
  input  logic              rd_req,
  input  logic              bus_done,
  output logic [ADDR_W-1:0] dir_bin,
  output logic              dec_en,
  output logic              wr_rd,
  output logic              bus_go,
  output logic              wr_ack,
  output logic              rd_ack,
  output logic              err,
  output logic              busy,
  output logic [2:0]        state_dbg
);

  // Handshake: wr_req/rd_req are levels held by the requester until the matching
  // one-cycle ack; they are sampled only in IDLE. bus_go starts one transaction at
  // dir_bin and the bus driver answers with a one-cycle bus_done, seen only in WAIT.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    DONE  = 3'd3,
    ERR   = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_REGS - 1);
  localparam logic [7:0]        TO_LAST  = 8'(TIMEOUT - 1);

  state_t            state, state_nx;
  logic [ADDR_W-1:0] index;
  logic [7:0]        to_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (wr_req || rd_req) state_nx = ISSUE;
      ISSUE: state_nx = WAIT;
      WAIT: begin
        if (bus_done)              state_nx = (index == LAST_IDX) ? DONE : ISSUE;
        else if (to_cnt == TO_LAST) state_nx = ERR;
      end
      DONE:    state_nx = IDLE;
      ERR:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Address index, stall counter and sweep direction; direction only changes at grant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      index  <= '0;
      to_cnt <= '0;
      wr_rd  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (wr_req) begin
            wr_rd <= 1'b1;
            index <= '0;
          end else if (rd_req) begin
            wr_rd <= 1'b0;
            index <= '0;
          end
        end
        ISSUE: to_cnt <= '0;
        WAIT: begin
          if (bus_done) begin
            if (index != LAST_IDX) index <= index + 1'b1;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    dir_bin = index;
    dec_en  = (state == ISSUE) || (state == WAIT);
    bus_go  = (state == ISSUE);
    wr_ack  = (state == DONE) && wr_rd;
    rd_ack  = (state == DONE) && !wr_rd;
    err     = (state == ERR);
    busy    = (state != IDLE);
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_dir_sweep_sched.sv
// Directed bench for dir_sweep_sched: sweep timing, arbitration, bus latency,
// timeout abort/retry, stray bus_done and asynchronous reset mid-sweep.
`timescale 1ns/1ps
module tb_dir_sweep_sched;
  logic       clk, reset, wr_req, rd_req, bus_done;
  logic [3:0] dir_bin;
  logic       dec_en, wr_rd, bus_go, wr_ack, rd_ack, err, busy;
  logic [2:0] state_dbg;

  int checks = 0;
  int failures = 0;
  int cyc;
  int go_cnt, ack_cyc, err_cyc, go_cyc_last, first_go_cyc;
  logic wr_ack_seen, rd_ack_seen, stable_ok, wr_rd_go, found;
  logic [3:0] exp_q[$];

  dir_sweep_sched #(.ADDR_W(4), .N_REGS(9), .TIMEOUT(255)) dut (
    .clk(clk), .reset(reset), .wr_req(wr_req), .rd_req(rd_req), .bus_done(bus_done),
    .dir_bin(dir_bin), .dec_en(dec_en), .wr_rd(wr_rd), .bus_go(bus_go),
    .wr_ack(wr_ack), .rd_ack(rd_ack), .err(err), .busy(busy), .state_dbg(state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock; inputs are driven and outputs sampled 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Responsive bus driver: bus_done on the lat-th WAIT cycle, never at stall_addr.
  task automatic sweep(input int lat, input int stall_addr, input int budget);
    int wcnt;
    logic [3:0] wait_addr;
    logic [3:0] exp_a;
    go_cnt = 0; ack_cyc = -1; err_cyc = -1; go_cyc_last = -1; first_go_cyc = -1;
    wr_ack_seen = 0; rd_ack_seen = 0; stable_ok = 1; wr_rd_go = 0;
    wcnt = 0; wait_addr = '0;
    exp_q.delete();
    for (int a = 0; a < 9; a++) exp_q.push_back(4'(a));
    for (int i = 0; i < budget; i++) begin
      step();
      bus_done = 1'b0;
      if (bus_go) begin
        exp_a = (exp_q.size() > 0) ? exp_q.pop_front() : 4'hf;
        check("go_addr", 32'(dir_bin), 32'(exp_a));
        if (first_go_cyc < 0) first_go_cyc = cyc;
        go_cnt++;
        go_cyc_last = cyc;
        wr_rd_go = wr_rd;
        wcnt = 0;
        wait_addr = dir_bin;
      end else if (dec_en) begin
        wcnt++;
        if (dir_bin != wait_addr) stable_ok = 0;
        if (wcnt == lat && dir_bin != stall_addr) bus_done = 1'b1;
      end
      if (wr_ack || rd_ack) begin
        ack_cyc = cyc; wr_ack_seen = wr_ack; rd_ack_seen = rd_ack;
        break;
      end
      if (err) begin
        err_cyc = cyc;
        break;
      end
    end
  endtask

  task automatic wait_ack(input int budget);
    ack_cyc = -1; rd_ack_seen = 0; wr_ack_seen = 0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (wr_ack || rd_ack) begin
        ack_cyc = cyc; wr_ack_seen = wr_ack; rd_ack_seen = rd_ack;
        break;
      end
    end
  endtask

  initial begin
    reset = 1'b1; wr_req = 0; rd_req = 0; bus_done = 0; cyc = 0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", 32'({dir_bin, dec_en, wr_rd, bus_go, wr_ack, rd_ack, err, busy}), 0);
    check("reset_state", 32'(state_dbg), 0);
    #2 reset = 1'b0;
    step();
    check("idle_busy", 32'(busy), 0);

    // Read sweep, minimum bus latency
    cyc = 0; rd_req = 1;
    sweep(1, -1, 40);
    check("rd_ack_cycle", ack_cyc, 19);
    check("rd_go_count", go_cnt, 9);
    check("rd_ack_seen", 32'(rd_ack_seen), 1);
    check("rd_no_wr_ack", 32'(wr_ack_seen), 0);
    check("rd_wr_rd", 32'(wr_rd_go), 0);
    rd_req = 0;
    step();
    check("rd_busy_low_c20", 32'(busy), 0);
    check("rd_cycle20", cyc, 20);
    step();

    // Both requests in IDLE: write first, then pending read
    cyc = 0; wr_req = 1; rd_req = 1;
    sweep(1, -1, 40);
    check("wr_ack_cycle", ack_cyc, 19);
    check("wr_ack_seen", 32'(wr_ack_seen), 1);
    check("wr_wr_rd", 32'(wr_rd_go), 1);
    wr_req = 0;
    sweep(1, -1, 40);
    check("rd2_first_go", first_go_cyc, 21);
    check("rd2_ack_cycle", ack_cyc, 39);
    check("rd2_ack_seen", 32'(rd_ack_seen), 1);
    check("rd2_wr_rd", 32'(wr_rd_go), 0);
    rd_req = 0;
    repeat (2) step();

    // Bus latency 3
    cyc = 0; rd_req = 1;
    sweep(3, -1, 60);
    check("lat3_ack_cycle", ack_cyc, 37);
    check("lat3_go_count", go_cnt, 9);
    check("lat3_stable", 32'(stable_ok), 1);
    rd_req = 0;
    repeat (2) step();

    // Timeout at address 2, then retry of the still-requested write
    cyc = 0; wr_req = 1;
    sweep(1, 2, 400);
    check("to_go_count", go_cnt, 3);
    check("to_last_go", go_cyc_last, 5);
    check("to_err_cycle", err_cyc, 261);
    check("to_no_ack", 32'({wr_ack_seen, rd_ack_seen}), 0);
    sweep(1, -1, 40);
    check("retry_first_go", first_go_cyc, 263);
    check("retry_ack_cycle", ack_cyc, 281);
    check("retry_wr_ack", 32'(wr_ack_seen), 1);
    wr_req = 0;
    repeat (2) step();

    // Stray bus_done in IDLE and during ISSUE
    bus_done = 1;
    repeat (3) step();
    check("stray_idle_busy", 32'(busy), 0);
    check("stray_idle_go", 32'(bus_go), 0);
    cyc = 0; rd_req = 1;
    step();
    check("stray_issue_go", 32'(bus_go), 1);
    step();
    bus_done = 0;
    check("stray_wait_go", 32'(bus_go), 0);
    check("stray_wait_addr", 32'(dir_bin), 0);
    check("stray_wait_en", 32'(dec_en), 1);
    step();
    check("stray_hold_addr", 32'({bus_go, dir_bin}), 0);
    bus_done = 1;
    wait_ack(40);
    check("stray_ack_cycle", ack_cyc, 20);
    check("stray_rd_ack", 32'(rd_ack_seen), 1);
    rd_req = 0; bus_done = 0;
    repeat (2) step();

    // Asynchronous reset while waiting on address 5
    cyc = 0; rd_req = 1; bus_done = 1; found = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (dec_en && !bus_go && dir_bin == 4'd5) begin
        found = 1;
        break;
      end
    end
    check("rst_reached_addr5", 32'(found), 1);
    bus_done = 0;
    #2 reset = 1'b1;
    #1;
    check("rst_async_outputs", 32'({dir_bin, dec_en, wr_rd, bus_go, wr_ack, rd_ack, err, busy}), 0);
    check("rst_async_state", 32'(state_dbg), 0);
    #2 reset = 1'b0;
    step();
    cyc = 1;
    check("rst_restart_go", 32'(bus_go), 1);
    check("rst_restart_addr", 32'(dir_bin), 0);
    bus_done = 1;
    wait_ack(40);
    check("rst_ack_cycle", ack_cyc, 19);
    check("rst_rd_ack", 32'(rd_ack_seen), 1);
    rd_req = 0; bus_done = 0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
